// File: rtl/const_mem_arbiter.sv
// rtl/const_mem_arbiter.sv - constant-ROM arbiter for three requesters plus write-priority sample-RAM port arbiter
// Optional: define CONST_ARB_ROUND_ROBIN_EN for round-robin ROM arbitration (default fixed priority 0 > 1 > 2).
module const_mem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [2:0]        Req_I,
   input  logic [ADDR_W-1:0] Addr0_I,
   input  logic [ADDR_W-1:0] Addr1_I,
   input  logic [ADDR_W-1:0] Addr2_I,
   output logic [2:0]        Grant_O,
   output logic [2:0]        Valid_O,
   output logic [DATA_W-1:0] Data_O,
   output logic              ROM_Enable_O,
   output logic [ADDR_W-1:0] ROM_Address_O,
   input  logic [DATA_W-1:0] ROM_Data_I,
   input  logic              Wr_Req_I,
   input  logic [ADDR_W-1:0] Wr_Addr_I,
   input  logic [DATA_W-1:0] Wr_Data_I,
   output logic              Wr_Grant_O,
   input  logic              Rd_Req_I,
   input  logic [ADDR_W-1:0] Rd_Addr_I,
   output logic              Rd_Grant_O,
   output logic              Rd_Valid_O,
   output logic [DATA_W-1:0] Rd_Data_O,
   output logic [ADDR_W-1:0] RAM_Address_O,
   output logic              RAM_Wen_O,
   output logic [DATA_W-1:0] RAM_Data_O,
   input  logic [DATA_W-1:0] RAM_Data_I
);

   logic [2:0]        grant_d, grant_q, tag1_q, valid_q;
   logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
   logic [DATA_W-1:0] data_q;
   logic              rom_en_q;
`ifdef CONST_ARB_ROUND_ROBIN_EN
   logic [1:0]        rr_ptr_d, rr_ptr_q;
`endif

   logic              wr_grant_d, rd_grant_d, wr_grant_q, rd_grant_q;
   logic              ram_wen_q, rd_tag1_q, rd_valid_q;
   logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_d, ram_wdata_q, rd_data_q;

   always_comb begin
      grant_d = 3'b000;
`ifdef CONST_ARB_ROUND_ROBIN_EN
      rr_ptr_d = rr_ptr_q;
      case (rr_ptr_q)
         2'd1:    grant_d = Req_I[1] ? 3'b010 : (Req_I[2] ? 3'b100 : (Req_I[0] ? 3'b001 : 3'b000));
         2'd2:    grant_d = Req_I[2] ? 3'b100 : (Req_I[0] ? 3'b001 : (Req_I[1] ? 3'b010 : 3'b000));
         default: grant_d = Req_I[0] ? 3'b001 : (Req_I[1] ? 3'b010 : (Req_I[2] ? 3'b100 : 3'b000));
      endcase
      // Priority restarts just after the requester that won.
      if (grant_d[0])      rr_ptr_d = 2'd1;
      else if (grant_d[1]) rr_ptr_d = 2'd2;
      else if (grant_d[2]) rr_ptr_d = 2'd0;
`else
      grant_d = Req_I[0] ? 3'b001 : (Req_I[1] ? 3'b010 : (Req_I[2] ? 3'b100 : 3'b000));
`endif
      rom_addr_d = rom_addr_q;
      if (grant_d[0])      rom_addr_d = Addr0_I;
      else if (grant_d[1]) rom_addr_d = Addr1_I;
      else if (grant_d[2]) rom_addr_d = Addr2_I;
   end

   // A read losing to a write is not latched; the requester keeps Rd_Req_I up until granted.
   always_comb begin
      wr_grant_d  = Wr_Req_I;
      rd_grant_d  = Rd_Req_I & ~Wr_Req_I;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if (wr_grant_d) begin
         ram_addr_d  = Wr_Addr_I;
         ram_wdata_d = Wr_Data_I;
      end else if (rd_grant_d) begin
         ram_addr_d  = Rd_Addr_I;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         grant_q     <= '0;
         tag1_q      <= '0;
         valid_q     <= '0;
         rom_en_q    <= 1'b0;
         rom_addr_q  <= '0;
         data_q      <= '0;
`ifdef CONST_ARB_ROUND_ROBIN_EN
         rr_ptr_q    <= 2'd0;
`endif
         wr_grant_q  <= 1'b0;
         rd_grant_q  <= 1'b0;
         ram_wen_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rd_tag1_q   <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         grant_q     <= grant_d;
         rom_en_q    <= |grant_d;
         rom_addr_q  <= rom_addr_d;
         tag1_q      <= grant_q;
         valid_q     <= tag1_q;
         if (|tag1_q) data_q <= ROM_Data_I;
`ifdef CONST_ARB_ROUND_ROBIN_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
         wr_grant_q  <= wr_grant_d;
         rd_grant_q  <= rd_grant_d;
         ram_wen_q   <= wr_grant_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         rd_tag1_q   <= rd_grant_q;
         rd_valid_q  <= rd_tag1_q;
         if (rd_tag1_q) rd_data_q <= RAM_Data_I;
      end
   end

   assign Grant_O       = grant_q;
   assign Valid_O       = valid_q;
   assign Data_O        = data_q;
   assign ROM_Enable_O  = rom_en_q;
   assign ROM_Address_O = rom_addr_q;
   assign Wr_Grant_O    = wr_grant_q;
   assign Rd_Grant_O    = rd_grant_q;
   assign Rd_Valid_O    = rd_valid_q;
   assign Rd_Data_O     = rd_data_q;
   assign RAM_Address_O = ram_addr_q;
   assign RAM_Wen_O     = ram_wen_q;
   assign RAM_Data_O    = ram_wdata_q;

endmodule

// File: tb/tb_const_mem_arbiter.sv
// tb/tb_const_mem_arbiter.sv - scoreboard bench for const_mem_arbiter with ROM/RAM models
module tb_const_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  Req_I;
   logic [9:0]  Addr0_I, Addr1_I, Addr2_I;
   logic [2:0]  Grant_O, Valid_O;
   logic [15:0] Data_O;
   logic        ROM_Enable_O;
   logic [9:0]  ROM_Address_O;
   logic [15:0] ROM_Data_I;
   logic        Wr_Req_I;
   logic [9:0]  Wr_Addr_I;
   logic [15:0] Wr_Data_I;
   logic        Wr_Grant_O;
   logic        Rd_Req_I;
   logic [9:0]  Rd_Addr_I;
   logic        Rd_Grant_O, Rd_Valid_O;
   logic [15:0] Rd_Data_O;
   logic [9:0]  RAM_Address_O;
   logic        RAM_Wen_O;
   logic [15:0] RAM_Data_O;
   logic [15:0] RAM_Data_I;

   const_mem_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
      .clock(clock), .reset(reset),
      .Req_I(Req_I), .Addr0_I(Addr0_I), .Addr1_I(Addr1_I), .Addr2_I(Addr2_I),
      .Grant_O(Grant_O), .Valid_O(Valid_O), .Data_O(Data_O),
      .ROM_Enable_O(ROM_Enable_O), .ROM_Address_O(ROM_Address_O), .ROM_Data_I(ROM_Data_I),
      .Wr_Req_I(Wr_Req_I), .Wr_Addr_I(Wr_Addr_I), .Wr_Data_I(Wr_Data_I), .Wr_Grant_O(Wr_Grant_O),
      .Rd_Req_I(Rd_Req_I), .Rd_Addr_I(Rd_Addr_I), .Rd_Grant_O(Rd_Grant_O),
      .Rd_Valid_O(Rd_Valid_O), .Rd_Data_O(Rd_Data_O),
      .RAM_Address_O(RAM_Address_O), .RAM_Wen_O(RAM_Wen_O), .RAM_Data_O(RAM_Data_O),
      .RAM_Data_I(RAM_Data_I)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Synchronous-read BRAM models: ROM word = {address, 6'b0}, RAM read-first.
   logic [15:0] rom_rd_q;
   logic [15:0] ram_mem [1024];
   logic [15:0] ram_rd_q;
   always @(posedge clock) if (ROM_Enable_O) rom_rd_q <= {ROM_Address_O, 6'b0};
   always @(posedge clock) begin
      if (RAM_Wen_O) ram_mem[RAM_Address_O] <= RAM_Data_O;
      ram_rd_q <= ram_mem[RAM_Address_O];
   end
   assign ROM_Data_I = rom_rd_q;
   assign RAM_Data_I = ram_rd_q;

   typedef struct { int due; logic [2:0] tag; logic [15:0] data; } rom_exp_t;
   typedef struct { int due; logic [15:0] data; } rd_exp_t;
   rom_exp_t rom_q [$];
   rd_exp_t  rd_q  [$];
   rom_exp_t re;
   rd_exp_t  de;

   logic [15:0] mem_model [1024];
   int          cyc = 0;
   logic        started = 1'b0;
   logic [1:0]  m_ptr, m_k, m_win;
   logic [2:0]  exp_grant;
   logic [9:0]  exp_addr, exp_ram_addr;
   logic [15:0] exp_ram_data;
   logic        exp_wr, exp_rd;

   // Reference model: evaluates the inputs of the cycle ending at this edge.
   always @(posedge clock) begin
      if (reset) begin
         started = 1'b1;
         m_ptr = 2'd0;
         exp_grant = 3'b000; exp_addr = '0; exp_wr = 1'b0; exp_rd = 1'b0;
         exp_ram_addr = '0; exp_ram_data = '0;
         rom_q.delete();
         rd_q.delete();
      end else if (started) begin
         exp_grant = 3'b000;
         m_win = 2'd0;
         for (int i = 0; i < 3; i++) begin
            m_k = 2'((int'(m_ptr) + i) % 3);
            if (exp_grant == 3'b000 && Req_I[m_k]) begin
               exp_grant = 3'b001 << m_k;
               m_win = m_k;
            end
         end
         if (exp_grant != 3'b000) begin
            exp_addr = (m_win == 2'd0) ? Addr0_I : ((m_win == 2'd1) ? Addr1_I : Addr2_I);
            rom_q.push_back('{cyc + 3, exp_grant, {exp_addr, 6'b0}});
`ifdef CONST_ARB_ROUND_ROBIN_EN
            m_ptr = (m_win == 2'd2) ? 2'd0 : m_win + 2'd1;
`endif
         end
         exp_wr = Wr_Req_I;
         exp_rd = Rd_Req_I && !Wr_Req_I;
         if (exp_wr) begin
            exp_ram_addr = Wr_Addr_I;
            exp_ram_data = Wr_Data_I;
            mem_model[Wr_Addr_I] = Wr_Data_I;
         end else if (exp_rd) begin
            exp_ram_addr = Rd_Addr_I;
            rd_q.push_back('{cyc + 3, mem_model[Rd_Addr_I]});
         end
      end
      cyc++;
   end

   always @(negedge clock) begin
      if (started) begin
         check("grant", 32'(Grant_O), 32'(exp_grant));
         check("rom_en", 32'(ROM_Enable_O), 32'(|exp_grant));
         if (exp_grant != 3'b000) check("rom_addr", 32'(ROM_Address_O), 32'(exp_addr));
         check("wr_grant", 32'(Wr_Grant_O), 32'(exp_wr));
         check("rd_grant", 32'(Rd_Grant_O), 32'(exp_rd));
         check("ram_wen", 32'(RAM_Wen_O), 32'(exp_wr));
         if (exp_wr || exp_rd) check("ram_addr", 32'(RAM_Address_O), 32'(exp_ram_addr));
         if (exp_wr) check("ram_wdata", 32'(RAM_Data_O), 32'(exp_ram_data));

         if (Valid_O != 3'b000) begin
            if (rom_q.size() == 0) check("valid_spurious", 32'(Valid_O), 32'd0);
            else begin
               re = rom_q.pop_front();
               check("valid_tag", 32'(Valid_O), 32'(re.tag));
               check("rom_data", 32'(Data_O), 32'(re.data));
               check("valid_cycle", 32'(cyc), 32'(re.due));
            end
         end else if (rom_q.size() > 0 && rom_q[0].due <= cyc) begin
            re = rom_q.pop_front();
            check("valid_missing", 32'(Valid_O), 32'(re.tag));
         end

         if (Rd_Valid_O) begin
            if (rd_q.size() == 0) check("rd_valid_spurious", 32'(Rd_Valid_O), 32'd0);
            else begin
               de = rd_q.pop_front();
               check("rd_data", 32'(Rd_Data_O), 32'(de.data));
               check("rd_valid_cycle", 32'(cyc), 32'(de.due));
            end
         end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            de = rd_q.pop_front();
            check("rd_valid_missing", 32'(Rd_Valid_O), 32'd1);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"},    32'(Grant_O),       32'd0);
      check({tag, "_valid"},    32'(Valid_O),       32'd0);
      check({tag, "_data"},     32'(Data_O),        32'd0);
      check({tag, "_rom_en"},   32'(ROM_Enable_O),  32'd0);
      check({tag, "_rom_addr"}, 32'(ROM_Address_O), 32'd0);
      check({tag, "_wr_grant"}, 32'(Wr_Grant_O),    32'd0);
      check({tag, "_rd_grant"}, 32'(Rd_Grant_O),    32'd0);
      check({tag, "_rd_valid"}, 32'(Rd_Valid_O),    32'd0);
      check({tag, "_rd_data"},  32'(Rd_Data_O),     32'd0);
      check({tag, "_ram_addr"}, 32'(RAM_Address_O), 32'd0);
      check({tag, "_ram_wen"},  32'(RAM_Wen_O),     32'd0);
      check({tag, "_ram_data"}, 32'(RAM_Data_O),    32'd0);
   endtask

   // Read requester: holds Rd_Req_I until it sees Rd_Grant_O, bounded.
   task automatic wait_rd_grant(input string tag);
      for (int t = 0; t < 16 && Rd_Req_I; t++) begin
         if (Rd_Grant_O) Rd_Req_I = 1'b0;
         else step();
      end
      if (Rd_Req_I) begin
         check({tag, "_rd_grant_timeout"}, 32'd0, 32'd1);
         Rd_Req_I = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram_mem[i]   = 16'h0000;
         mem_model[i] = 16'h0000;
      end
      reset = 1'b1;
      Req_I = 3'b000; Addr0_I = '0; Addr1_I = '0; Addr2_I = '0;
      Wr_Req_I = 1'b0; Wr_Addr_I = '0; Wr_Data_I = '0;
      Rd_Req_I = 1'b0; Rd_Addr_I = '0;
      @(posedge clock);
      @(negedge clock);
      check_all_zero("reset");
      step();
      reset = 1'b0;

      // Single request, requester 0 at 0x010 -> word 0x0400.
      Req_I = 3'b001; Addr0_I = 10'h010;
      step();
      Req_I = 3'b000;
      repeat (4) step();

      // All three requesting for six cycles.
      Req_I = 3'b111; Addr0_I = 10'h001; Addr1_I = 10'h102; Addr2_I = 10'h203;
      repeat (6) step();
      Req_I = 3'b000;
      repeat (4) step();

      // Simultaneous write and read of 0x300.
      Wr_Req_I = 1'b1; Wr_Addr_I = 10'h300; Wr_Data_I = 16'hBEEF;
      Rd_Req_I = 1'b1; Rd_Addr_I = 10'h300;
      step();
      Wr_Req_I = 1'b0;
      wait_rd_grant("wr_rd_same");
      repeat (4) step();

      // Read pending behind four consecutive writes.
      Rd_Req_I = 1'b1; Rd_Addr_I = 10'h055;
      for (int i = 0; i < 4; i++) begin
         Wr_Req_I = 1'b1; Wr_Addr_I = (i == 2) ? 10'h055 : 10'(10'h100 + i); Wr_Data_I = 16'(16'h1111 * (i + 1));
         step();
         check("rd_held_while_writing", 32'(Rd_Grant_O), 32'd0);
      end
      Wr_Req_I = 1'b0;
      wait_rd_grant("held_read");
      repeat (4) step();

      // Random mixed traffic on both ports.
      for (int i = 0; i < 150; i++) begin
         Req_I    = 3'($urandom_range(0, 7));
         Addr0_I  = 10'($urandom); Addr1_I = 10'($urandom); Addr2_I = 10'($urandom);
         Wr_Req_I = ($urandom_range(0, 3) == 0);
         Wr_Addr_I = 10'($urandom_range(0, 15)); Wr_Data_I = 16'($urandom);
         Rd_Req_I = ($urandom_range(0, 1) == 1);
         Rd_Addr_I = 10'($urandom_range(0, 15));
         step();
      end
      Req_I = 3'b000; Wr_Req_I = 1'b0; Rd_Req_I = 1'b0;
      repeat (5) step();

      // Reset one cycle after Grant_O=010 squashes the in-flight responses.
      Req_I = 3'b010; Addr1_I = 10'h0A5;
      Rd_Req_I = 1'b1; Rd_Addr_I = 10'h300;
      step();
      Req_I = 3'b000; Rd_Req_I = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clock);
      check_all_zero("post_reset");
      repeat (4) step();

      for (int t = 0; t < 20 && (rom_q.size() > 0 || rd_q.size() > 0); t++) step();
      check("drain_rom", 32'(rom_q.size()), 32'd0);
      check("drain_rd", 32'(rd_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/const_mem_arbiter.md
CONST_MEM_ARBITER -- requirements
Module: const_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: address width of both BRAM ports.
REQ-002 SHALL have parameter DATA_W, default 16: data width of both BRAM ports.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clock  in  1  sole clock, all logic rising-edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 Req_I  in  3  ROM read request per requester (0 header/alloc, 1 dequant, 2 synthesis window).
REQ-006 Addr0_I, Addr1_I, Addr2_I  in  ADDR_W each  ROM address per requester, held while Req high.
REQ-007 Grant_O  in/out: out  3  one-hot, requester's address was issued this cycle.
REQ-008 Valid_O  out  3  one-hot, Data_O holds that requester's word.
REQ-009 Data_O  out  DATA_W  registered ROM read data.
REQ-010 ROM_Enable_O  out  1;  ROM_Address_O  out  ADDR_W;  ROM_Data_I  in  DATA_W: BRAM port A.
REQ-011 Wr_Req_I  in  1;  Wr_Addr_I  in  ADDR_W;  Wr_Data_I  in  DATA_W;  Wr_Grant_O  out  1: sample write port.
REQ-012 Rd_Req_I  in  1;  Rd_Addr_I  in  ADDR_W;  Rd_Grant_O  out  1;  Rd_Valid_O  out  1;  Rd_Data_O  out  DATA_W: sample read port.
REQ-013 RAM_Address_O  out  ADDR_W;  RAM_Wen_O  out  1;  RAM_Data_O  out  DATA_W;  RAM_Data_I  in  DATA_W: BRAM port B.

Function
REQ-014 SHALL sample Req_I in cycle N, register winner: Grant_O, ROM_Enable_O=1, ROM_Address_O=winner address in N+1.
REQ-015 SHALL capture ROM_Data_I in N+2 and present Data_O with Valid_O one-hot in N+3 (fixed 3-cycle latency).
REQ-016 SHALL issue at most one ROM grant per cycle; sustained throughput one access/cycle.
REQ-017 Requester holding Req_I high after Grant_O SHALL be treated as a new request (back-to-back allowed).
REQ-018 Requester SHALL drop Req_I the cycle Grant_O is seen if no further access; arbiter SHALL not re-grant a request deasserted in the sampling cycle.
REQ-019 ROM_Enable_O SHALL be 0 and Grant_O 0 in cycles with no request; ROM_Address_O holds last value.
REQ-020 Port B: write SHALL have priority over read; sampled in N, RAM_Wen_O/RAM_Address_O/RAM_Data_O and Wr_Grant_O driven in N+1.
REQ-021 Granted read SHALL drive RAM_Wen_O=0, Rd_Grant_O in N+1; Rd_Valid_O with registered Rd_Data_O in N+3.
REQ-022 Simultaneous Wr/Rd to same address: write granted first, read granted next cycle, read SHALL return newly written data.
REQ-023 A read pending behind continuous writes SHALL be held (not dropped) until granted.
REQ-024 Valid pipeline SHALL be tracked per-request tag; no response lost or duplicated under back-to-back grants.

Reset
REQ-025 On reset: Grant_O, Valid_O, Data_O, ROM_Enable_O, ROM_Address_O, Wr_Grant_O, Rd_Grant_O, Rd_Valid_O, Rd_Data_O, RAM_Address_O, RAM_Wen_O, RAM_Data_O all 0; round-robin pointer to requester 0.
REQ-026 Reset mid-operation SHALL squash all in-flight responses; no Valid_O/Rd_Valid_O in the cycle after reset deasserts.

Configuration
REQ-027 With CONST_ARB_ROUND_ROBIN_EN defined: ROM arbitration round-robin; after granting k, priority order starts at (k+1) mod 3.
REQ-028 Without CONST_ARB_ROUND_ROBIN_EN: fixed priority, requester 0 > 1 > 2; pointer logic absent.

Verification
REQ-029 Req_I=001, Addr0_I=0x010 at N -> Grant_O=001, ROM_Address_O=0x010 at N+1; Valid_O=001, Data_O=0x0400 (first word of that row) at N+3.
REQ-030 Req_I=111 held 6 cycles, RR enabled -> grant order 0,1,2,0,1,2; Valid_O follows same order, 3 cycles later.
REQ-031 Same with RR disabled -> Grant_O=001 every cycle; requesters 1,2 starve until Req_I[0] drops.
REQ-032 Wr_Req_I+Rd_Req_I same cycle, addr 0x300, Wr_Data_I=0xBEEF -> Wr_Grant_O at N+1, Rd_Grant_O at N+2, Rd_Data_O=0xBEEF with Rd_Valid_O at N+4.
REQ-033 Reset asserted one cycle after Grant_O=010 -> no Valid_O ever for that request; all outputs 0 next cycle.
